axi_lite_rr_master: RTL and testbench
=====================================

# axi_lite_rr_master

Round-robin AXI-Lite master that shares the single 4-register AXI-Lite slave between `NUM_REQ` internal requesters. Each requester issues simple single-beat read/write commands; the block grants one at a time, sequences the AW/W → B or AR → R handshakes on the shared `axi_if`, and returns the response to the granted requester. It sits between the requester logic and `dif`, and is the only AXI-Lite master on that interface.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, ≥2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester command valid. Held until `req_ready`.
- `req_ready`  out  NUM_REQ: one-hot accept pulse. The command is latched in this cycle.
- `req_write`  in  NUM_REQ: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ×ADDR_W: byte address.
- `req_wdata`  in  NUM_REQ×DATA_W: write data. Ignored for reads.
- `rsp_valid`  out  NUM_REQ: one-hot, single-cycle completion pulse. There is no backpressure.
- `rsp_rdata`  out  DATA_W: read data, valid with `rsp_valid`. Writes return 0.
- `rsp_resp`  out  2: captured BRESP/RRESP, valid with `rsp_valid`.
- `dif`  master  axi_if: drives awvalid/awaddr, wvalid/wdata, bready, arvalid/araddr, rready. Samples the ready, valid, data and resp signals.

## Operation
- FSM states are IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP and DONE.
- **IDLE**
  - Grant the first requester with `req_valid` high, searching from `rr_ptr` upward modulo NUM_REQ.
  - Pulse `req_ready[g]`.
  - Latch write, addr and wdata, and record g.
  - Set `rr_ptr <= (g+1) % NUM_REQ`.
  - Go to WR_REQ or RD_REQ.
  - With no valid requester, stay in IDLE and leave the pointer unchanged.
- **WR_REQ**
  - Assert awvalid and wvalid together, with awaddr and wdata from the latch.
  - Leave only when awready and wready are both high in the same cycle; the slave commits only on a same-cycle AW/W handshake.
  - Never drop one valid without the other.
  - Then go to WR_RSP.
- **WR_RSP**: bready=1. On bvalid, capture bresp and go to DONE.
- **RD_REQ**: assert arvalid with araddr until arready, then go to RD_RSP.
- **RD_RSP**: rready=1. On rvalid, capture rdata and rresp and go to DONE.
- **DONE**
  - Pulse `rsp_valid[g]` for one cycle with the captured rdata and resp.
  - Return to IDLE.
- RESP values pass through unchanged: OKAY=2'b00, SLVERR=2'b10.
- Only one transaction is outstanding at any time. Read and write channels are never active together.
- Requests that arrive while the FSM is busy wait with `req_valid` held. Their data may change until they are accepted.

## Timing
- **Reset values**
  - All valid/ready/pulse outputs are 0: `req_ready`, `rsp_valid`, awvalid, wvalid, arvalid, bready, rready.
  - awaddr, araddr, wdata, `rsp_rdata` and `rsp_resp` are 0.
  - `rr_ptr` = 0 and the state is IDLE.
- **Reset mid-transaction**: the transaction is abandoned immediately and no `rsp_valid` is issued. The slave is reset by the same `rst_n`.
- **Latency, zero-wait slave, grant in cycle T**
  - AW/W (or AR) is asserted and accepted in T+1.
  - bvalid (or rvalid) arrives in T+3.
  - DONE and `rsp_valid` occur in T+4.
  - The earliest next grant is T+5.
- Slave wait states extend WR_REQ, RD_REQ, WR_RSP and RD_RSP without limit. There is no timeout.
- `req_ready` is high only in IDLE. `rsp_valid` is high only in DONE.
- Simultaneous requests: the first at/after `rr_ptr` wins. A continuously requesting set is served strictly in rotating order, so no requester starves.

## Structure
- Package `axi_lite_arb_pkg`:
  - `state_e` enum (the six states above).
  - RESP constants `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10.
- Sub-module `rr_grant`:
  - Combinational round-robin picker.
  - Inputs: `req_valid` vector and `rr_ptr`.
  - Outputs: `grant_valid`, `grant_idx` ($clog2(NUM_REQ) bits).
  - The FSM, latches and pointer register stay in the top module.

## Test plan
- **Single write:** req0 writes 0xDEADBEEF to 0x4 in T.
  - Requester side: `req_ready[0]` pulses in T; `rsp_valid[0]` pulses in T+4 with resp=00 and rdata=0.
  - AXI side: awvalid and wvalid are high together in T+1.
  - Check: register 1 = 0xDEADBEEF.
- **Readback:** write 0x12345678 to 0xC, then read 0xC.
  - `rsp_rdata` = 0x12345678 and resp=00.
  - `rsp_valid` comes 4 cycles after grant.
- **Contention:** req0 and req1 both hold writes from reset.
  - Grant order is 0, 1, 0, 1.
  - Each `rsp_valid` is one-hot for the granted requester.
  - No `req_ready` pulses during a transaction.
- **Backpressure:** the slave stubs awready low for 3 cycles while wready stays high.
  - wvalid stays asserted.
  - The write commits once and exactly one bvalid is consumed.
- **Error passthrough:** a stub slave returns rresp=2'b10 with rdata=0xA5A5A5A5.
  - `rsp_resp` = 2'b10 and `rsp_rdata` = 0xA5A5A5A5.
- **Reset mid-op:** assert `rst_n` low during WR_RSP.
  - All outputs are 0 on the next sample.
  - No `rsp_valid` is issued.
  - After release, a new req1 read is granted first because `rr_ptr` is 0 and req0 is idle.

Source files
------------

// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the round-robin AXI-Lite master.
package axi_lite_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP,
        DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_if.sv
// Single AXI-Lite bus bundle shared between one master and one slave.
interface axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_rr_master_rr_grant.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               grant_valid,
    output logic [PTR_W-1:0]   grant_idx
);

    logic [NUM_REQ-1:0] rotated;
    logic [PTR_W:0]     sum;

    // Rotate so bit 0 is the requester at rr_ptr, take the lowest set bit,
    // then map the offset back to an absolute index modulo NUM_REQ.
    always_comb begin
        rotated     = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        grant_valid = |rotated;
        sum         = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            end
        end
        if (sum >= (PTR_W+1)'(NUM_REQ)) begin
            sum = sum - (PTR_W+1)'(NUM_REQ);
        end
        grant_idx = sum[PTR_W-1:0];
    end

endmodule

// File: rtl/axi_lite_rr_master.sv
// Round-robin AXI-Lite master: grants one requester at a time and runs a
// single-beat read or write on the shared bus, returning the response.
module axi_lite_rr_master
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    axi_if.master                     dif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e            state, state_next;
    logic [PTR_W-1:0]  rr_ptr, gnt_idx, cur_idx, next_ptr;
    logic              grant_valid;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cap_rdata;
    logic [1:0]        cap_resp;

    rr_grant #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_grant (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (gnt_idx)
    );

    assign next_ptr   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign dif.awaddr = lat_addr;
    assign dif.araddr = lat_addr;
    assign dif.wdata  = lat_wdata;
    assign rsp_rdata  = cap_rdata;
    assign rsp_resp   = cap_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // AW and W are raised and dropped together because the slave only
    // commits a write on a same-cycle handshake of both channels.
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        rsp_valid   = '0;
        dif.awvalid = 1'b0;
        dif.wvalid  = 1'b0;
        dif.bready  = 1'b0;
        dif.arvalid = 1'b0;
        dif.rready  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_next = req_write[gnt_idx] ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                dif.awvalid = 1'b1;
                dif.wvalid  = 1'b1;
                if (dif.awready && dif.wready) state_next = WR_RSP;
            end
            WR_RSP: begin
                dif.bready = 1'b1;
                if (dif.bvalid) state_next = DONE;
            end
            RD_REQ: begin
                dif.arvalid = 1'b1;
                if (dif.arready) state_next = RD_RSP;
            end
            RD_RSP: begin
                dif.rready = 1'b1;
                if (dif.rvalid) state_next = DONE;
            end
            DONE: begin
                rsp_valid[cur_idx] = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cur_idx   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cap_rdata <= '0;
            cap_resp  <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_idx   <= gnt_idx;
                        lat_addr  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                        lat_wdata <= req_wdata[gnt_idx*DATA_W +: DATA_W];
                        rr_ptr    <= next_ptr;
                    end
                end
                WR_RSP: begin
                    if (dif.bvalid) begin
                        cap_rdata <= '0;
                        cap_resp  <= dif.bresp;
                    end
                end
                RD_RSP: begin
                    if (dif.rvalid) begin
                        cap_rdata <= dif.rdata;
                        cap_resp  <= dif.rresp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rr_master.sv
// Scoreboard bench for axi_lite_rr_master with a 4-register AXI-Lite slave stub.
module tb_axi_lite_rr_master;
    import axi_lite_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid, req_ready, req_write, rsp_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [1:0]                rsp_resp;

    axi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif_bus ();

    axi_lite_rr_master #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .dif       (dif_bus)
    );

    // Slave stub: commit one cycle after the AW/W handshake, respond the cycle after.
    logic [31:0] regs [4];
    int          stall_cycles = 0;
    bit          err_mode     = 1'b0;
    int          aw_wait_cnt, commit_count, b_count, bp_cycles;
    logic        wr_pend, rd_pend;
    logic [1:0]  rd_sel;

    assign dif_bus.awready = (aw_wait_cnt >= stall_cycles);
    assign dif_bus.wready  = 1'b1;
    assign dif_bus.arready = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend <= 1'b0; rd_pend <= 1'b0; rd_sel <= 2'd0;
            dif_bus.bvalid <= 1'b0; dif_bus.bresp <= 2'b00;
            dif_bus.rvalid <= 1'b0; dif_bus.rdata <= '0; dif_bus.rresp <= 2'b00;
            aw_wait_cnt <= 0; commit_count <= 0; b_count <= 0; bp_cycles <= 0;
        end else begin
            wr_pend <= 1'b0;
            if (dif_bus.awvalid && dif_bus.awready && dif_bus.wvalid && dif_bus.wready) begin
                regs[dif_bus.awaddr[3:2]] <= dif_bus.wdata;
                wr_pend      <= 1'b1;
                commit_count <= commit_count + 1;
                aw_wait_cnt  <= 0;
            end else if (dif_bus.awvalid && !dif_bus.awready) begin
                aw_wait_cnt <= aw_wait_cnt + 1;
                bp_cycles   <= bp_cycles + 1;
            end
            if (wr_pend) begin
                dif_bus.bvalid <= 1'b1;
                dif_bus.bresp  <= RESP_OKAY;
            end else if (dif_bus.bvalid && dif_bus.bready) begin
                dif_bus.bvalid <= 1'b0;
                b_count        <= b_count + 1;
            end
            rd_pend <= dif_bus.arvalid && dif_bus.arready;
            if (dif_bus.arvalid && dif_bus.arready) rd_sel <= dif_bus.araddr[3:2];
            if (rd_pend) begin
                dif_bus.rvalid <= 1'b1;
                dif_bus.rdata  <= err_mode ? 32'hA5A5_A5A5 : regs[rd_sel];
                dif_bus.rresp  <= err_mode ? RESP_SLVERR : RESP_OKAY;
            end else if (dif_bus.rvalid && dif_bus.rready) begin
                dif_bus.rvalid <= 1'b0;
            end
        end
    end

    typedef struct { int idx; logic [31:0] rdata; logic [1:0] resp; int lat; } rsp_t;
    typedef struct { int idx; bit write; } gnt_t;
    rsp_t rsp_q[$];
    gnt_t gnt_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int proto_err = 0;
    int grant_cycle;
    bit busy = 1'b0;
    bit axi_pending = 1'b0;
    bit axi_write;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        checkOutput({tag, "_valids"}, {27'd0, dif_bus.awvalid, dif_bus.wvalid, dif_bus.arvalid,
                                       dif_bus.bready, dif_bus.rready}, 0);
        checkOutput({tag, "_awaddr"}, dif_bus.awaddr, 0);
        checkOutput({tag, "_araddr"}, dif_bus.araddr, 0);
        checkOutput({tag, "_wdata"}, dif_bus.wdata, 0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 0);
        checkOutput({tag, "_rsp_resp"}, 32'(rsp_resp), 0);
    endtask

    // Monitor: pops the grant and response scoreboards as the DUT presents them.
    initial begin
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                axi_pending = 1'b0;
            end else begin
                if ((dif_bus.awvalid !== dif_bus.wvalid) || (dif_bus.arvalid && dif_bus.awvalid))
                    proto_err++;
                if (axi_pending) begin
                    axi_pending = 1'b0;
                    checkOutput(axi_write ? "aw_w_in_t1" : "ar_in_t1",
                                {29'd0, dif_bus.awvalid, dif_bus.wvalid, dif_bus.arvalid},
                                axi_write ? 32'b110 : 32'b001);
                end
                if (req_ready != 0) begin
                    if (gnt_q.size() == 0) begin
                        checkOutput("unexpected_grant", 32'(req_ready), 0);
                    end else begin
                        g = gnt_q.pop_front();
                        checkOutput("grant_onehot", 32'(req_ready), 32'(1) << g.idx);
                        checkOutput("grant_while_busy", 32'(busy), 0);
                        busy = 1'b1;
                        grant_cycle = cycle;
                        axi_pending = 1'b1;
                        axi_write = g.write;
                    end
                end
                if (rsp_valid != 0) begin
                    if (rsp_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'(rsp_valid), 0);
                    end else begin
                        r = rsp_q.pop_front();
                        checkOutput("rsp_onehot", 32'(rsp_valid), 32'(1) << r.idx);
                        checkOutput("rsp_rdata", rsp_rdata, r.rdata);
                        checkOutput("rsp_resp", 32'(rsp_resp), 32'(r.resp));
                        checkOutput("rsp_latency", 32'(cycle - grant_cycle), 32'(r.lat));
                    end
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input int idx, input bit write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic [1:0] exp_resp, input int exp_lat, input bit expect_rsp);
        bit got = 1'b0;
        gnt_q.push_back('{idx, write});
        if (expect_rsp) rsp_q.push_back('{idx, exp_rdata, exp_resp, exp_lat});
        @(posedge clk); #1;
        req_write[idx] = write;
        req_addr[idx*ADDR_W +: ADDR_W]  = addr;
        req_wdata[idx*DATA_W +: DATA_W] = wdata;
        req_valid[idx] = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1'b1;
        end
        if (!got) checkOutput("grant_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        req_wdata[idx*DATA_W +: DATA_W] = 32'hFFFF_FFFF;
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 200 && (rsp_q.size() != 0 || busy); c++) @(negedge clk);
        #1;
        checkOutput("drain_pending", 32'(rsp_q.size() + gnt_q.size()), 0);
    endtask

    initial begin
        int cnt [NUM_REQ];
        logic [NUM_REQ-1:0] drop;
        int c0, b0, p0;
        bit found;

        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        #1 rst_n = 1'b0;
        #2 checkAllZero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention: both requesters hold writes straight out of reset.
        for (int i = 0; i < 2; i++) begin
            gnt_q.push_back('{0, 1'b1});
            gnt_q.push_back('{1, 1'b1});
            rsp_q.push_back('{0, 32'h0, RESP_OKAY, 4});
            rsp_q.push_back('{1, 32'h0, RESP_OKAY, 4});
        end
        cnt = '{default: 0};
        drop = '0;
        @(posedge clk); #1;
        req_write = 2'b11;
        req_addr  = {32'h0000_0004, 32'h0000_0000};
        req_wdata = {32'h2222_2222, 32'h1111_1111};
        req_valid = 2'b11;
        for (int c = 0; c < 200 && req_valid != 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 2) drop[i] = 1'b1;
                end
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~drop;
        end
        checkOutput("contention_done", 32'(req_valid), 0);
        waitDrain();

        // Single write, then write/readback through the other requester.
        applyStimulus(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 32'h0, RESP_OKAY, 4, 1'b1);
        waitDrain();
        checkOutput("reg1_value", regs[1], 32'hDEAD_BEEF);
        applyStimulus(1, 1'b1, 32'hC, 32'h1234_5678, 32'h0, RESP_OKAY, 4, 1'b1);
        waitDrain();
        applyStimulus(0, 1'b0, 32'hC, 32'h0, 32'h1234_5678, RESP_OKAY, 4, 1'b1);
        waitDrain();

        // Backpressure: awready low for three cycles while wready stays high.
        c0 = commit_count; b0 = b_count; p0 = bp_cycles;
        stall_cycles = 3;
        applyStimulus(1, 1'b1, 32'h8, 32'hCAFE_F00D, 32'h0, RESP_OKAY, 7, 1'b1);
        waitDrain();
        stall_cycles = 0;
        checkOutput("bp_commits", 32'(commit_count - c0), 1);
        checkOutput("bp_bvalids", 32'(b_count - b0), 1);
        checkOutput("bp_stall_cycles", 32'(bp_cycles - p0), 3);
        checkOutput("reg2_value", regs[2], 32'hCAFE_F00D);

        // Error passthrough, then a normal read of the contention data.
        err_mode = 1'b1;
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, RESP_SLVERR, 4, 1'b1);
        waitDrain();
        err_mode = 1'b0;
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 32'h1111_1111, RESP_OKAY, 4, 1'b1);
        waitDrain();

        // Reset while waiting for B: no response may follow.
        applyStimulus(0, 1'b1, 32'h8, 32'h0BAD_BEEF, 32'h0, RESP_OKAY, 4, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (dif_bus.bready) found = 1'b1;
        end
        checkOutput("reached_wr_rsp", 32'(found), 1);
        rst_n = 1'b0;
        #1 checkAllZero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 32'h0BAD_BEEF, RESP_OKAY, 4, 1'b1);
        waitDrain();
        repeat (3) @(negedge clk);

        checkOutput("protocol_errors", 32'(proto_err), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
